// File: rtl/hex_distributor_pkg.sv
// Shared definitions for the six-channel stream selector/distributor pair.
// Holds the channel count, the channel index width, the distributor FSM
// state type, and the cfg-to-channel decode used identically on both sides.
package hex_distributor_pkg;

    localparam int NUM_CH = 6;
    localparam int CH_W   = 3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Config word to channel index: 0..5 map straight through, 6 and 7 fall back to channel 0.
    function automatic logic [CH_W-1:0] decode_cfg(input logic [2:0] cfg_v);
        logic [CH_W-1:0] ch;
        case (cfg_v)
            3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5: ch = cfg_v;
            default:                            ch = 3'd0;
        endcase
        return ch;
    endfunction

    // Channel index to one-hot lane vector.
    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
        logic [NUM_CH-1:0] oh;
        for (int n = 0; n < NUM_CH; n++) begin
            oh[n] = (ch == CH_W'(n));
        end
        return oh;
    endfunction

endpackage

// File: rtl/hex_distributor_reg.sv
// One-beat output holding register with a destination index.
// Ports:
//   clk_i, rst_i   clock and asynchronous active-high reset
//   load_i         capture data_i/last_i for lane dest_i (only asserted when ready_o)
//   m_tready_i     per-lane ready from the consumers
//   ready_o        register can accept a beat this cycle
//   tdata_o        all lane data; only the destination lane is rewritten on load
//   tvalid_o/tlast_o  one-hot per-lane valid/last, zero on lanes not addressed
module hex_distributor_reg
    import hex_distributor_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         load_i,
    input  logic [DATA_WIDTH-1:0]        data_i,
    input  logic                         last_i,
    input  logic [CH_W-1:0]              dest_i,
    input  logic [NUM_CH-1:0]            m_tready_i,
    output logic                         ready_o,
    output logic [NUM_CH*DATA_WIDTH-1:0] tdata_o,
    output logic [NUM_CH-1:0]            tvalid_o,
    output logic [NUM_CH-1:0]            tlast_o
);

    logic                         valid_q, valid_d;
    logic                         last_q, last_d;
    logic [CH_W-1:0]              dest_q, dest_d;
    logic [NUM_CH*DATA_WIDTH-1:0] lanes_q, lanes_d;
    logic [NUM_CH-1:0]            tvalid_q, tvalid_d;
    logic [NUM_CH-1:0]            tlast_q, tlast_d;

    // Pass-through ready: the slot frees up in the same cycle the destination drains it.
    always_comb begin
        ready_o = !valid_q || m_tready_i[dest_q];
    end

    // Next-state for the holding slot and the per-lane output views.
    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        dest_d  = dest_q;
        if (load_i) begin
            valid_d = 1'b1;
            last_d  = last_i;
            dest_d  = dest_i;
        end else if (m_tready_i[dest_q]) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        // Lanes not addressed keep whatever they last carried.
        lanes_d = lanes_q;
        for (int n = 0; n < NUM_CH; n++) begin
            if (load_i && (dest_i == CH_W'(n))) begin
                lanes_d[n*DATA_WIDTH +: DATA_WIDTH] = data_i;
            end else begin
                lanes_d[n*DATA_WIDTH +: DATA_WIDTH] = lanes_q[n*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        tvalid_d = valid_d ? ch_onehot(dest_d) : {NUM_CH{1'b0}};
        tlast_d  = (valid_d && last_d) ? ch_onehot(dest_d) : {NUM_CH{1'b0}};
    end

    // Holding slot and registered lane outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            dest_q   <= {CH_W{1'b0}};
            lanes_q  <= {(NUM_CH*DATA_WIDTH){1'b0}};
            tvalid_q <= {NUM_CH{1'b0}};
            tlast_q  <= {NUM_CH{1'b0}};
        end else begin
            valid_q  <= valid_d;
            last_q   <= last_d;
            dest_q   <= dest_d;
            lanes_q  <= lanes_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end

    assign tdata_o  = lanes_q;
    assign tvalid_o = tvalid_q;
    assign tlast_o  = tlast_q;

endmodule

// File: rtl/hex_distributor.sv
// Six-way AXI4-Stream demultiplexer. The destination is taken from cfg at
// the first beat of each packet and locked until the tlast beat is accepted,
// so a packet never splits across channels. One-cycle registered output.
// Ports:
//   aclk, areset        clock, asynchronous active-high reset
//   cfg                 destination select (sampled at packet start only)
//   s_axis_*            input stream
//   m_axis_*            six output channels, lane n at tdata[(n+1)*W-1:n*W]
//   sel                 locked channel index
//   busy                packet in progress
module hex_distributor
    import hex_distributor_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [2:0]                   cfg,
    input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
    input  logic                         s_axis_tvalid,
    input  logic                         s_axis_tlast,
    output logic                         s_axis_tready,
    output logic [NUM_CH*DATA_WIDTH-1:0] m_axis_tdata,
    output logic [NUM_CH-1:0]            m_axis_tvalid,
    output logic [NUM_CH-1:0]            m_axis_tlast,
    input  logic [NUM_CH-1:0]            m_axis_tready,
    output logic [CH_W-1:0]              sel,
    output logic                         busy
);

    state_e          state_q, state_d;
    logic [CH_W-1:0] sel_q, sel_d;
    logic [CH_W-1:0] route_s;
    logic            ready_s;
    logic            accept_s;

    assign accept_s = s_axis_tvalid && ready_s;

    // State and lock registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= ST_IDLE;
            sel_q   <= {CH_W{1'b0}};
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    // Next-state: a non-last beat opens a packet, a last beat closes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && !s_axis_tlast) begin
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (accept_s && s_axis_tlast) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Routing: in IDLE the beat follows cfg live (and the lock tracks it);
    // in BUSY the lock is frozen and cfg is ignored.
    always_comb begin
        route_s = sel_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: begin
                route_s = decode_cfg(cfg);
                sel_d   = route_s;
            end
            ST_BUSY: begin
                route_s = sel_q;
                sel_d   = sel_q;
            end
            default: begin
                route_s = {CH_W{1'b0}};
                sel_d   = {CH_W{1'b0}};
            end
        endcase
    end

    hex_distributor_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_reg (
        .clk_i      (aclk),
        .rst_i      (areset),
        .load_i     (accept_s),
        .data_i     (s_axis_tdata),
        .last_i     (s_axis_tlast),
        .dest_i     (route_s),
        .m_tready_i (m_axis_tready),
        .ready_o    (ready_s),
        .tdata_o    (m_axis_tdata),
        .tvalid_o   (m_axis_tvalid),
        .tlast_o    (m_axis_tlast)
    );

    assign s_axis_tready = ready_s;
    assign sel           = sel_q;
    assign busy          = (state_q == ST_BUSY);

endmodule

// File: tb/tb_hex_distributor.sv
// Scoreboard bench for hex_distributor: the driver records each accepted beat
// with its expected channel, the monitor pops on every output transfer.
module tb_hex_distributor;

    localparam int DW  = 32;
    localparam int NCH = 6;

    logic              aclk = 1'b0;
    logic              areset = 1'b1;
    logic [2:0]        cfg = 3'd0;
    logic [DW-1:0]     s_tdata = '0;
    logic              s_tvalid = 1'b0;
    logic              s_tlast = 1'b0;
    logic              s_tready;
    logic [NCH*DW-1:0] m_tdata;
    logic [NCH-1:0]    m_tvalid;
    logic [NCH-1:0]    m_tlast;
    logic [NCH-1:0]    m_tready = 6'h3f;
    logic [2:0]        sel;
    logic              busy;

    hex_distributor #(.DATA_WIDTH(DW)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .cfg           (cfg),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .sel           (sel),
        .busy          (busy)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [2:0]    ch;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t      exp_q[$];
    int         cmp_cnt = 0;
    int         mis_cnt = 0;
    int         cyc = 0;
    bit         rand_ready = 1'b0;
    bit         rand_cfg = 1'b0;
    bit         in_pkt_exp = 1'b0;
    logic [2:0] lock_exp = 3'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference destination rule: configs 6 and 7 go to channel 0.
    function automatic logic [2:0] chan_of(input logic [2:0] c);
        return (c < 3'd6) ? c : 3'd0;
    endfunction

    always @(posedge aclk) cyc++;

    // Consumer ready pattern.
    always @(posedge aclk) begin
        #1;
        if (rand_ready) begin
            for (int n = 0; n < NCH; n++) m_tready[n] = ($urandom_range(0, 3) != 0);
        end else begin
            m_tready = 6'h3f;
        end
    end

    // Monitor: transfers against scoreboard, lane holding, stall stability.
    logic [DW-1:0]  last_seen [NCH];
    logic [DW-1:0]  prev_data [NCH];
    logic [NCH-1:0] prev_hold;
    logic [DW-1:0]  lane;
    beat_t          got;
    int             nvalid;

    always @(negedge aclk) begin
        if (areset) begin
            for (int n = 0; n < NCH; n++) begin
                last_seen[n] = '0;
                prev_data[n] = '0;
            end
            prev_hold = '0;
        end else begin
            nvalid = $countones(m_tvalid);
            check("onehot_valid", 64'(nvalid <= 1), 64'd1);
            check("s_tready", 64'(s_tready), 64'((m_tvalid == 6'd0) || ((m_tvalid & m_tready) != 6'd0)));
            for (int n = 0; n < NCH; n++) begin
                lane = m_tdata[n*DW +: DW];
                if (prev_hold[n]) begin
                    check("stall_valid", 64'(m_tvalid[n]), 64'd1);
                    check("stall_data", 64'(lane), 64'(prev_data[n]));
                end
                if (m_tvalid[n]) begin
                    if (m_tready[n]) begin
                        if (exp_q.size() == 0) begin
                            cmp_cnt++;
                            mis_cnt++;
                            $display("FAIL unexpected_beat: lane %0d data %0h with empty scoreboard", n, lane);
                        end else begin
                            got = exp_q.pop_front();
                            check("dest_ch", 64'(n), 64'(got.ch));
                            check("data", 64'(lane), 64'(got.data));
                            check("tlast", 64'(m_tlast[n]), 64'(got.last));
                        end
                    end
                    last_seen[n] = lane;
                    prev_data[n] = lane;
                    prev_hold[n] = !m_tready[n];
                end else begin
                    check("idle_lane_hold", 64'(lane), 64'(last_seen[n]));
                    check("tlast_gated", 64'(m_tlast[n]), 64'd0);
                    prev_hold[n] = 1'b0;
                end
            end
        end
    end

    // Offer one beat until accepted; record the expectation at the accept cycle.
    task automatic send_beat(input logic [DW-1:0] d, input bit last, input bit first);
        int  waitc = 0;
        bit  done = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        while (!done) begin
            @(negedge aclk);
            check("busy", 64'(busy), 64'(in_pkt_exp));
            if (in_pkt_exp) check("sel_lock", 64'(sel), 64'(lock_exp));
            if (s_tready) begin
                if (first) lock_exp = chan_of(cfg);
                exp_q.push_back({lock_exp, d, last});
                in_pkt_exp = !last;
                done = 1'b1;
            end else begin
                waitc++;
                if (waitc > 200) begin
                    cmp_cnt++;
                    mis_cnt++;
                    $display("FAIL accept_timeout: beat %0h never accepted", d);
                    done = 1'b1;
                end
            end
            @(posedge aclk);
            #1;
            if (rand_cfg) cfg = 3'($urandom_range(0, 7));
        end
        s_tvalid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge aclk);
            check("busy_idle", 64'(busy), 64'(in_pkt_exp));
            @(posedge aclk);
            #1;
            if (rand_cfg) cfg = 3'($urandom_range(0, 7));
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_tvalid"}, 64'(m_tvalid), 64'd0);
        check({tag, "_tlast"}, 64'(m_tlast), 64'd0);
        check({tag, "_sel"}, 64'(sel), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_s_tready"}, 64'(s_tready), 64'd1);
    endtask

    initial begin
        int t0;
        int len;
        int wd;
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        check_reset_state("reset");
        check("reset_tdata", 64'(m_tdata == '0), 64'd1);
        areset = 1'b0;
        idle_cycles(2);

        // 4-beat packet to channel 3 at full rate.
        cfg = 3'd3;
        t0 = cyc;
        for (int i = 0; i < 4; i++) send_beat(32'h10 + 32'(i), (i == 3), (i == 0));
        check("burst_cycles", 64'(cyc - t0), 64'd4);

        // cfg changes mid-packet must not move the packet.
        cfg = 3'd2;
        for (int i = 0; i < 4; i++) begin
            send_beat(32'h200 + 32'(i), (i == 3), (i == 0));
            if (i == 1) cfg = 3'd5;
        end
        send_beat(32'h500, 1'b1, 1'b1);

        // Out-of-range configs route to channel 0, single-beat packets.
        cfg = 3'd6;
        send_beat(32'hAA, 1'b1, 1'b1);
        cfg = 3'd7;
        send_beat(32'hBB, 1'b1, 1'b1);

        // Back-to-back packets ch0 then ch4 with no gap.
        cfg = 3'd0;
        t0 = cyc;
        send_beat(32'hC0, 1'b0, 1'b1);
        send_beat(32'hC1, 1'b1, 1'b0);
        cfg = 3'd4;
        send_beat(32'hD0, 1'b0, 1'b1);
        send_beat(32'hD1, 1'b1, 1'b0);
        check("b2b_cycles", 64'(cyc - t0), 64'd4);

        // Randomized traffic with consumer stalls and live cfg churn.
        rand_ready = 1'b1;
        rand_cfg = 1'b1;
        for (int p = 0; p < 300; p++) begin
            len = $urandom_range(1, 4);
            if (p == 150) len = 3;
            for (int b = 0; b < len; b++) begin
                send_beat($urandom, (b == len - 1), (b == 0));
                if (p == 150 && b == 0) begin
                    // Reset with a beat in flight: it is dropped.
                    areset = 1'b1;
                    #1;
                    check_reset_state("midrst");
                    exp_q.delete();
                    in_pkt_exp = 1'b0;
                    @(posedge aclk);
                    #1;
                    areset = 1'b0;
                    break;
                end
            end
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
        end

        // Drain.
        rand_ready = 1'b0;
        wd = 0;
        while (exp_q.size() != 0 && wd < 50) begin
            @(posedge aclk);
            wd++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
